// File: rtl/realtank_busmtx_pkg.sv
// ---------------------------------------------------------------------------
// realtank_busmtx_pkg
//   Shared definitions for the bus-matrix output-port arbiter:
//   - htrans_t      : AHB HTRANS encodings
//   - arb_state_t   : output-port arbiter states
//   - DEFAULT_PORT_IDX : index reported while the output port is parked
//   - is_seq_or_busy() : true for HTRANS values that continue a burst
// ---------------------------------------------------------------------------
package realtank_busmtx_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {
        PARK  = 2'b00,
        XFER  = 2'b01,
        BURST = 2'b10,
        LOCK  = 2'b11
    } arb_state_t;

    localparam int DEFAULT_PORT_IDX = 0;

    function automatic logic is_seq_or_busy(input logic [1:0] trans);
        return (trans == HTRANS_SEQ) || (trans == HTRANS_BUSY);
    endfunction

endpackage

// File: rtl/realtank_soc_rr_pick.sv
// ---------------------------------------------------------------------------
// realtank_soc_rr_pick
//   Combinational rotate-priority encoder. Searches req starting at ptr+1
//   (modulo NUM_IN) and returns the first requester found.
//   Ports:
//     req    in  NUM_IN  request vector
//     ptr    in  IDX_W   index of the previous winner (must be < NUM_IN)
//     winner out IDX_W   selected index (0 when nothing found)
//     found  out 1       at least one request present
// ---------------------------------------------------------------------------
module realtank_soc_rr_pick #(
    parameter int NUM_IN = 3,
    parameter int IDX_W  = 3
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [IDX_W-1:0]  winner,
    output logic              found
);

    // cand[k] is the k-th index visited by the search; req_rot[k] its request.
    logic [IDX_W-1:0]  cand [NUM_IN];
    logic [NUM_IN-1:0] req_rot;

    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_cand
            localparam int OFS = gi + 1;
            logic [IDX_W:0] sum;
            logic           hit;

            // ptr < NUM_IN and OFS <= NUM_IN, so one conditional subtract
            // is enough to wrap back into 0..NUM_IN-1.
            assign sum = {1'b0, ptr} + (IDX_W+1)'(OFS);
            assign cand[gi] = (sum >= (IDX_W+1)'(NUM_IN))
                            ? IDX_W'(sum - (IDX_W+1)'(NUM_IN))
                            : sum[IDX_W-1:0];

            // Match against each legal index instead of indexing req directly,
            // so an index wider than needed can never select outside req.
            always_comb begin
                hit = 1'b0;
                for (int j = 0; j < NUM_IN; j++) begin
                    if (cand[gi] == IDX_W'(j)) begin
                        hit = req[j];
                    end
                end
            end
            assign req_rot[gi] = hit;
        end
    endgenerate

    // Walk from the far end so the earliest candidate in search order wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                found  = 1'b1;
                winner = cand[k];
            end
        end
    end

endmodule

// File: rtl/realtank_soc_bus_out_arb.sv
// ---------------------------------------------------------------------------
// realtank_soc_bus_out_arb
//   Round-robin arbiter for one bus-matrix output (slave) port. Picks one
//   input stage per address phase, holds the grant across bursts and locked
//   sequences, and tracks the data-phase owner.
//   Build option: define REALTANK_ARB_LOCK_EN to honour lock_in and build the
//   LOCK state; otherwise lock_in is ignored and locked transfers arbitrate
//   like ordinary ones.
//   Ports:
//     HCLK          in   AHB clock
//     HRESET        in   asynchronous reset, active high
//     req_in        in   per-input request (selected and not IDLE)
//     nonseq_in     in   per-input NONSEQ (burst start) indicator
//     lock_in       in   per-input HMASTLOCK
//     HTRANSM       in   HTRANS currently driven to the slave
//     HREADYM       in   HREADY of this output port
//     addr_in_port  out  address-phase owner index
//     data_in_port  out  data-phase owner index
//     no_port       out  no address-phase owner (slave sees IDLE)
//     active_out    out  one-hot address-phase owner flags
//     grant_valid   out  registered ~no_port for debug/perf counters
// ---------------------------------------------------------------------------
module realtank_soc_bus_out_arb
    import realtank_busmtx_pkg::*;
#(
    parameter int NUM_IN = 3,
    parameter int IDX_W  = 3
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic [NUM_IN-1:0] req_in,
    input  logic [NUM_IN-1:0] nonseq_in,
    input  logic [NUM_IN-1:0] lock_in,
    input  logic [1:0]        HTRANSM,
    input  logic              HREADYM,
    output logic [IDX_W-1:0]  addr_in_port,
    output logic [IDX_W-1:0]  data_in_port,
    output logic              no_port,
    output logic [NUM_IN-1:0] active_out,
    output logic              grant_valid
);

    arb_state_t       state_reg,   state_next;
    logic [IDX_W-1:0] addr_reg,    addr_next;
    logic [IDX_W-1:0] data_reg;
    logic [IDX_W-1:0] rr_ptr_reg,  rr_ptr_next;
    logic             no_port_reg, no_port_next;
    logic             grant_valid_reg;

    logic [NUM_IN-1:0] own_onehot;
    logic              req_own;
    logic              nonseq_own;
    logic              lock_own;
    logic              seq_busy;
    logic              do_arb;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_found;

    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_own
            assign own_onehot[gi] = (addr_reg == IDX_W'(gi));
            assign active_out[gi] = ~no_port_reg & own_onehot[gi];
        end
    endgenerate

    assign req_own    = |(req_in & own_onehot);
    assign nonseq_own = |(nonseq_in & own_onehot);
    assign seq_busy   = is_seq_or_busy(HTRANSM);

`ifdef REALTANK_ARB_LOCK_EN
    assign lock_own = |(lock_in & own_onehot);
`else
    logic unused_lock;
    assign unused_lock = ^lock_in;
    assign lock_own    = 1'b0;
`endif

    realtank_soc_rr_pick #(
        .NUM_IN (NUM_IN),
        .IDX_W  (IDX_W)
    ) u_pick (
        .req    (req_in),
        .ptr    (rr_ptr_reg),
        .winner (pick_idx),
        .found  (pick_found)
    );

    // Next-state: everything holds unless HREADYM completes the current beat.
    always_comb begin
        state_next   = state_reg;
        addr_next    = addr_reg;
        rr_ptr_next  = rr_ptr_reg;
        no_port_next = no_port_reg;
        do_arb       = 1'b0;

        if (HREADYM) begin
            case (state_reg)
                PARK: do_arb = 1'b1;
                XFER: begin
                    if (seq_busy) begin
                        state_next = BURST;
                    end else if (lock_own) begin
                        state_next = LOCK;
                    end else if (~req_own | nonseq_own) begin
                        do_arb = 1'b1;
                    end else begin
                        // Owner's next beat continues the burst.
                        state_next = BURST;
                    end
                end
                BURST: begin
                    // Release as soon as the owner's pending beat is not a
                    // continuation, so the next owner gets the slot without
                    // an idle gap.
                    if (~req_own | nonseq_own) begin
                        do_arb = 1'b1;
                    end
                end
`ifdef REALTANK_ARB_LOCK_EN
                LOCK: begin
                    if (~lock_own & ~seq_busy) begin
                        do_arb = 1'b1;
                    end
                end
`endif
                default: do_arb = 1'b1;
            endcase

            if (do_arb) begin
                if (pick_found) begin
                    state_next   = XFER;
                    addr_next    = pick_idx;
                    rr_ptr_next  = pick_idx;
                    no_port_next = 1'b0;
                end else begin
                    state_next   = PARK;
                    addr_next    = IDX_W'(DEFAULT_PORT_IDX);
                    no_port_next = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_reg       <= PARK;
            addr_reg        <= '0;
            data_reg        <= '0;
            rr_ptr_reg      <= '0;
            no_port_reg     <= 1'b1;
            grant_valid_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            addr_reg        <= addr_next;
            rr_ptr_reg      <= rr_ptr_next;
            no_port_reg     <= no_port_next;
            grant_valid_reg <= ~no_port_next;
            if (HREADYM) begin
                data_reg <= addr_reg;
            end
        end
    end

    assign addr_in_port = addr_reg;
    assign data_in_port = data_reg;
    assign no_port      = no_port_reg;
    assign grant_valid  = grant_valid_reg;

endmodule
